// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// BramPortArbiter (module bram_port_arbiter)
//
// Shares the single BRAM initiator port of the serial mailbox between two
// requesters: requester 0 is the inbound-message poller, requester 1 is the
// outbound-message writer. Arbitration is round-robin, and a bounded lock
// lets one requester own the port for atomic multi-word sequences such as a
// ring-pointer read-modify-write.
//
// Ports:
//   CLK, RST            clock (rising edge) and async active-high reset
//   rqN_req             request valid for requester N
//   rqN_lock            keep ownership of the port after this beat
//   rqN_be              byte write enables, all-zero means read
//   rqN_addr/rqN_wdata  word address and write data
//   rqN_gnt             combinational grant; req & gnt = accepted beat
//   rqN_rvalid/rdata    read return, two cycles after acceptance
//   bram_*              registered BRAM pins; bram_din is the BRAM read data
//   lock_timeout        sticky flag, set when a lock was force-released
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                CLK,
  input  logic                RST,

  input  logic                rq0_req,
  input  logic                rq0_lock,
  input  logic [DATA_W/8-1:0] rq0_be,
  input  logic [ADDR_W-1:0]   rq0_addr,
  input  logic [DATA_W-1:0]   rq0_wdata,
  output logic                rq0_gnt,
  output logic                rq0_rvalid,
  output logic [DATA_W-1:0]   rq0_rdata,

  input  logic                rq1_req,
  input  logic                rq1_lock,
  input  logic [DATA_W/8-1:0] rq1_be,
  input  logic [ADDR_W-1:0]   rq1_addr,
  input  logic [DATA_W-1:0]   rq1_wdata,
  output logic                rq1_gnt,
  output logic                rq1_rvalid,
  output logic [DATA_W-1:0]   rq1_rdata,

  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_dout,
  output logic [DATA_W/8-1:0] bram_wen,
  output logic                bram_en,
  output logic                bram_clk,
  output logic                bram_rst,
  input  logic [DATA_W-1:0]   bram_din,

  output logic                lock_timeout
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lockState_t;

  lockState_t       state;
  lockState_t       stateNext;
  logic             lockOwner;
  logic             ownerNext;
  logic [CNT_W-1:0] lockCnt;
  logic [CNT_W-1:0] cntNext;
  logic             lastGnt;
  logic             lastNext;
  logic             setTimeout;

  logic [1:0]       reqVec;
  logic [1:0]       lockVec;
  logic [1:0]       gntRaw;
  logic [1:0]       gnt;
  logic             accept;
  logic             accIdx;

  logic [BE_W-1:0]   selBe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  logic [1:0]        rdStage1;
  logic [1:0]        rdStage2;
  logic [DATA_W-1:0] rdHold0;
  logic [DATA_W-1:0] rdHold1;

  assign reqVec  = {rq1_req, rq0_req};
  assign lockVec = {rq1_lock, rq0_lock};

  assign bram_clk = CLK;
  assign bram_rst = RST;

  // Lock state register, lock counter and round-robin pointer. The pointer
  // resets to 1 so that requester 0 wins the first tie after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= UNLOCKED;
      lockOwner <= 1'b0;
      lockCnt   <= '0;
      lastGnt   <= 1'b1;
    end else begin
      state     <= stateNext;
      lockOwner <= ownerNext;
      lockCnt   <= cntNext;
      lastGnt   <= lastNext;
    end
  end

  // Grant selection and lock state machine. While locked only the owner can
  // be granted, even when it is idle. A release (owner beat with lock low, or
  // the counter reaching LOCK_MAX) only opens the port from the next cycle,
  // because the grant here is always decoded from the current state. An owner
  // release in the same cycle as the timeout counts as a normal release, so
  // it is checked first. On a forced release the pointer is set to the owner
  // so the other requester wins the next tie. Grants are forced low in reset.
  always_comb begin
    stateNext  = state;
    ownerNext  = lockOwner;
    cntNext    = lockCnt;
    lastNext   = lastGnt;
    setTimeout = 1'b0;
    gntRaw     = 2'b00;

    case (state)
      UNLOCKED: begin
        if (reqVec == 2'b11) begin
          gntRaw = lastGnt ? 2'b01 : 2'b10;
        end else begin
          gntRaw = reqVec;
        end
      end
      LOCKED: begin
        gntRaw[lockOwner] = reqVec[lockOwner];
      end
      default: gntRaw = 2'b00;
    endcase

    gnt    = RST ? 2'b00 : gntRaw;
    accept = gnt[0] | gnt[1];
    accIdx = gnt[1];

    case (state)
      UNLOCKED: begin
        if (accept) begin
          lastNext = accIdx;
          if (lockVec[accIdx]) begin
            stateNext = LOCKED;
            ownerNext = accIdx;
            cntNext   = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        cntNext = lockCnt + CNT_W'(1);
        if (accept) begin
          lastNext = lockOwner;
        end
        if (accept && !lockVec[lockOwner]) begin
          stateNext = UNLOCKED;
          cntNext   = '0;
        end else if (lockCnt == CNT_W'(LOCK_MAX)) begin
          stateNext  = UNLOCKED;
          cntNext    = '0;
          setTimeout = 1'b1;
          lastNext   = lockOwner;
        end
      end
      default: stateNext = UNLOCKED;
    endcase
  end

  assign rq0_gnt = gnt[0];
  assign rq1_gnt = gnt[1];

  assign selBe    = accIdx ? rq1_be    : rq0_be;
  assign selAddr  = accIdx ? rq1_addr  : rq0_addr;
  assign selWdata = accIdx ? rq1_wdata : rq0_wdata;

  // BRAM pin register. Address and write data hold their last value on idle
  // cycles; enable and write enables drop to zero so an idle cycle never
  // writes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bram_en   <= 1'b0;
      bram_wen  <= '0;
      bram_addr <= '0;
      bram_dout <= '0;
    end else begin
      bram_en  <= accept;
      bram_wen <= accept ? selBe : '0;
      if (accept) begin
        bram_addr <= selAddr;
        bram_dout <= selWdata;
      end
    end
  end

  // Read-return tracking. Stage 1 marks the cycle the BRAM is enabled for a
  // read, stage 2 the cycle its data sits on bram_din. Reset empties both so
  // reads in flight at reset never return.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdStage1 <= 2'b00;
      rdStage2 <= 2'b00;
    end else begin
      rdStage1 <= (selBe == '0) ? gnt : 2'b00;
      rdStage2 <= rdStage1;
    end
  end

  // Each requester keeps its last returned word until its next read returns.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdHold0 <= '0;
      rdHold1 <= '0;
    end else begin
      if (rdStage2[0]) begin
        rdHold0 <= bram_din;
      end
      if (rdStage2[1]) begin
        rdHold1 <= bram_din;
      end
    end
  end

  assign rq0_rvalid = rdStage2[0];
  assign rq1_rvalid = rdStage2[1];
  assign rq0_rdata  = rdStage2[0] ? bram_din : rdHold0;
  assign rq1_rdata  = rdStage2[1] ? bram_din : rdHold1;

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_timeout <= 1'b0;
    end else if (setTimeout) begin
      lock_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for bram_port_arbiter. A small read-only BRAM model returns
// preloaded words one cycle after bram_en. Each task drives one scenario and
// checks the outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int LOCK_MAX = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              rq0_req, rq0_lock, rq1_req, rq1_lock;
  logic [BE_W-1:0]   rq0_be, rq1_be;
  logic [ADDR_W-1:0] rq0_addr, rq1_addr;
  logic [DATA_W-1:0] rq0_wdata, rq1_wdata;
  logic              rq0_gnt, rq0_rvalid, rq1_gnt, rq1_rvalid;
  logic [DATA_W-1:0] rq0_rdata, rq1_rdata;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [BE_W-1:0]   bram_wen;
  logic              bram_en, bram_clk, bram_rst;
  logic [DATA_W-1:0] bram_din;
  logic              lock_timeout;

  logic [DATA_W-1:0] mem [0:63];
  logic [DATA_W-1:0] dinReg;

  int testsRun    = 0;
  int testsFailed = 0;

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .rq0_req(rq0_req), .rq0_lock(rq0_lock), .rq0_be(rq0_be), .rq0_addr(rq0_addr),
    .rq0_wdata(rq0_wdata), .rq0_gnt(rq0_gnt), .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
    .rq1_req(rq1_req), .rq1_lock(rq1_lock), .rq1_be(rq1_be), .rq1_addr(rq1_addr),
    .rq1_wdata(rq1_wdata), .rq1_gnt(rq1_gnt), .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
    .bram_addr(bram_addr), .bram_dout(bram_dout), .bram_wen(bram_wen), .bram_en(bram_en),
    .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_din(bram_din),
    .lock_timeout(lock_timeout)
  );

  always #5 CLK = ~CLK;

  // Read-only BRAM model with one cycle of read latency.
  always @(posedge CLK) begin
    if (bram_en) begin
      dinReg <= mem[bram_addr[5:0]];
    end
  end
  assign bram_din = dinReg;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleAll();
    rq0_req = 1'b0; rq0_lock = 1'b0; rq0_be = '0; rq0_addr = '0; rq0_wdata = '0;
    rq1_req = 1'b0; rq1_lock = 1'b0; rq1_be = '0; rq1_addr = '0; rq1_wdata = '0;
  endtask

  task automatic doReset();
    RST = 1'b1;
    idleAll();
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    idleAll();
    rq0_req = 1'b1;
    rq1_req = 1'b1;
    #2;
    testsRun++;
    if ({rq0_gnt, rq1_gnt} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL reset_gnt: got %b expected 00", {rq0_gnt, rq1_gnt});
    end
    testsRun++;
    if ({bram_en, bram_wen, bram_addr, bram_dout} !== '0) begin
      testsFailed++; $display("[TB] FAIL reset_bram: got en=%b wen=%h addr=%h dout=%h expected all 0",
                              bram_en, bram_wen, bram_addr, bram_dout);
    end
    testsRun++;
    if ({rq0_rvalid, rq1_rvalid, lock_timeout} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL reset_flags: got %b expected 000", {rq0_rvalid, rq1_rvalid, lock_timeout});
    end
    testsRun++;
    if (bram_rst !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL reset_bram_rst: got %b expected 1", bram_rst);
    end
    tick();
    RST = 1'b0;
    idleAll();
  endtask

  task automatic test_round_robin();
    logic exp0, exp1;
    doReset();
    for (int i = 0; i < 8; i++) begin
      rq0_req  = (i < 6);
      rq1_req  = (i < 6);
      rq0_addr = 14'h0001;
      rq1_addr = 14'h0002;
      #1;
      exp0 = (i < 6) && (i % 2 == 0);
      exp1 = (i < 6) && (i % 2 == 1);
      testsRun++;
      if ({rq0_gnt, rq1_gnt} !== {exp0, exp1}) begin
        testsFailed++; $display("[TB] FAIL rr_gnt cycle %0d: got %b expected %b", i, {rq0_gnt, rq1_gnt}, {exp0, exp1});
      end
      if (i >= 2) begin
        testsRun++;
        if ({rq0_rvalid, rq1_rvalid} !== {(i % 2 == 0), (i % 2 == 1)}) begin
          testsFailed++; $display("[TB] FAIL rr_rvalid cycle %0d: got %b expected %b", i,
                                  {rq0_rvalid, rq1_rvalid}, {(i % 2 == 0), (i % 2 == 1)});
        end
        testsRun++;
        if (i % 2 == 0 && rq0_rdata !== 32'h1111_1111) begin
          testsFailed++; $display("[TB] FAIL rr_rdata0 cycle %0d: got %h expected 11111111", i, rq0_rdata);
        end else if (i % 2 == 1 && rq1_rdata !== 32'h2222_2222) begin
          testsFailed++; $display("[TB] FAIL rr_rdata1 cycle %0d: got %h expected 22222222", i, rq1_rdata);
        end
      end
      tick();
    end
    idleAll();
  endtask

  task automatic test_read();
    rq0_req  = 1'b1;
    rq0_addr = 14'h0005;
    rq0_be   = '0;
    #1;
    testsRun++;
    if (rq0_gnt !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL read_gnt: got %b expected 1", rq0_gnt);
    end
    tick();
    idleAll();
    #1;
    testsRun++;
    if ({bram_en, bram_addr, bram_wen} !== {1'b1, 14'h0005, 4'h0}) begin
      testsFailed++; $display("[TB] FAIL read_bram: got en=%b addr=%h wen=%h expected en=1 addr=0005 wen=0",
                              bram_en, bram_addr, bram_wen);
    end
    testsRun++;
    if (rq0_rvalid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL read_early_rvalid: got %b expected 0", rq0_rvalid);
    end
    tick();
    #1;
    testsRun++;
    if ({rq0_rvalid, rq1_rvalid, rq0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      testsFailed++; $display("[TB] FAIL read_return: got rvalid=%b%b rdata=%h expected rvalid=10 rdata=deadbeef",
                              rq0_rvalid, rq1_rvalid, rq0_rdata);
    end
    tick();
    #1;
    testsRun++;
    if ({rq0_rvalid, rq0_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      testsFailed++; $display("[TB] FAIL read_hold: got rvalid=%b rdata=%h expected rvalid=0 rdata=deadbeef",
                              rq0_rvalid, rq0_rdata);
    end
  endtask

  task automatic test_write();
    rq1_req   = 1'b1;
    rq1_be    = 4'b0011;
    rq1_addr  = 14'h0010;
    rq1_wdata = 32'hA5A5_A5A5;
    #1;
    testsRun++;
    if ({rq0_gnt, rq1_gnt} !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL write_gnt: got %b expected 01", {rq0_gnt, rq1_gnt});
    end
    tick();
    idleAll();
    #1;
    testsRun++;
    if ({bram_en, bram_wen, bram_addr, bram_dout} !== {1'b1, 4'b0011, 14'h0010, 32'hA5A5_A5A5}) begin
      testsFailed++; $display("[TB] FAIL write_bram: got en=%b wen=%b addr=%h dout=%h expected 1 0011 0010 a5a5a5a5",
                              bram_en, bram_wen, bram_addr, bram_dout);
    end
    tick();
    #1;
    testsRun++;
    if ({bram_en, bram_wen, bram_addr, bram_dout} !== {1'b0, 4'b0000, 14'h0010, 32'hA5A5_A5A5}) begin
      testsFailed++; $display("[TB] FAIL write_idle: got en=%b wen=%b addr=%h dout=%h expected 0 0000 0010 a5a5a5a5",
                              bram_en, bram_wen, bram_addr, bram_dout);
    end
    testsRun++;
    if (rq1_rvalid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL write_no_rvalid: got %b expected 0", rq1_rvalid);
    end
  endtask

  task automatic test_reset_midstream();
    rq0_req  = 1'b1;
    rq0_addr = 14'h0005;
    #1;
    tick();
    idleAll();
    RST     = 1'b1;
    rq1_req = 1'b1;
    #1;
    testsRun++;
    if ({bram_en, bram_wen, bram_addr, bram_dout} !== '0) begin
      testsFailed++; $display("[TB] FAIL midrst_bram: got en=%b wen=%h addr=%h dout=%h expected all 0",
                              bram_en, bram_wen, bram_addr, bram_dout);
    end
    testsRun++;
    if ({rq0_gnt, rq1_gnt, lock_timeout} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL midrst_gnt: got %b expected 000", {rq0_gnt, rq1_gnt, lock_timeout});
    end
    tick();
    testsRun++;
    if ({rq0_rvalid, rq1_rvalid} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL midrst_rvalid_in_reset: got %b expected 00", {rq0_rvalid, rq1_rvalid});
    end
    RST = 1'b0;
    idleAll();
    for (int i = 0; i < 2; i++) begin
      tick();
      testsRun++;
      if ({rq0_rvalid, rq1_rvalid} !== 2'b00) begin
        testsFailed++; $display("[TB] FAIL midrst_rvalid_after cycle %0d: got %b expected 00", i, {rq0_rvalid, rq1_rvalid});
      end
    end
  endtask

  task automatic test_lock_release();
    logic [4:0] vec [0:5];
    vec[0] = 5'b11_1_10;
    vec[1] = 5'b01_1_00;
    vec[2] = 5'b11_1_10;
    vec[3] = 5'b11_1_10;
    vec[4] = 5'b10_1_10;
    vec[5] = 5'b00_1_01;
    doReset();
    for (int i = 0; i < 6; i++) begin
      rq0_req  = vec[i][4];
      rq0_lock = vec[i][3];
      rq1_req  = vec[i][2];
      rq0_addr = 14'(i);
      rq1_addr = 14'h0020;
      #1;
      testsRun++;
      if ({rq0_gnt, rq1_gnt} !== vec[i][1:0]) begin
        testsFailed++; $display("[TB] FAIL lock_gnt cycle %0d: got %b expected %b", i, {rq0_gnt, rq1_gnt}, vec[i][1:0]);
      end
      tick();
    end
    idleAll();
    testsRun++;
    if (lock_timeout !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL lock_no_timeout: got %b expected 0", lock_timeout);
    end
    tick();
  endtask

  task automatic test_lock_timeout();
    rq1_req  = 1'b1;
    rq1_lock = 1'b1;
    rq1_be   = 4'hF;
    rq1_addr = 14'h0030;
    #1;
    testsRun++;
    if ({rq0_gnt, rq1_gnt} !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL tmo_lock_gnt: got %b expected 01", {rq0_gnt, rq1_gnt});
    end
    tick();
    for (int i = 1; i <= LOCK_MAX; i++) begin
      rq1_req  = 1'b0;
      rq1_lock = 1'b0;
      rq0_req  = 1'b1;
      #1;
      testsRun++;
      if ({rq0_gnt, rq1_gnt} !== 2'b00) begin
        testsFailed++; $display("[TB] FAIL tmo_blocked cycle %0d: got %b expected 00", i, {rq0_gnt, rq1_gnt});
      end
      tick();
    end
    rq1_req = 1'b1;
    rq0_req = 1'b1;
    #1;
    testsRun++;
    if ({rq0_gnt, rq1_gnt} !== 2'b10) begin
      testsFailed++; $display("[TB] FAIL tmo_after_gnt: got %b expected 10", {rq0_gnt, rq1_gnt});
    end
    testsRun++;
    if (lock_timeout !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL tmo_flag: got %b expected 1", lock_timeout);
    end
    tick();
    idleAll();
    tick();
    tick();
    testsRun++;
    if (lock_timeout !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL tmo_sticky: got %b expected 1", lock_timeout);
    end
    doReset();
    #1;
    testsRun++;
    if (lock_timeout !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL tmo_cleared: got %b expected 0", lock_timeout);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0;
    end
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;
    mem[5] = 32'hDEAD_BEEF;
    idleAll();

    test_reset();
    test_round_robin();
    test_read();
    test_write();
    test_reset_midstream();
    test_lock_release();
    test_lock_timeout();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
